// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_pkg
// Brief    : Shared FSM state encoding and width constants for the APB master.
// Revision : 1.0
// ============================================================================
package apb_pkg;

    localparam int APB_ADDR_W      = 32;
    localparam int APB_DATA_W      = 32;
    localparam int APB_TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_cmd_master
// Brief    : Single-command APB master with ready-wait timeout and response hold.
// Revision : 1.0
// ============================================================================
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DEF
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [APB_ADDR_W-1:0] cmd_addr,
    input  logic                  cmd_write,
    input  logic [APB_DATA_W-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [APB_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [APB_ADDR_W-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [APB_DATA_W-1:0] PWDATA,
    input  logic [APB_DATA_W-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    // Counter value on the last permitted not-ready ACCESS cycle
    localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    apb_state_e            state_q, state_d;
    logic [APB_ADDR_W-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
    logic [APB_DATA_W-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  tout_q, tout_d;
    logic [7:0]            cnt_q, cnt_d;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q  <= ST_IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            tout_q   <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            tout_q   <= tout_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        tout_d   = tout_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_wdata;
                    rdata_d  = '0;
                    tout_d   = 1'b0;
                    cnt_d    = 8'd0;
                    // Misaligned commands skip the bus and answer with an error
                    if (cmd_addr[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // A ready on the final counted cycle still wins over the timeout
                if (PREADY) begin
                    err_d   = PSLVERR;
                    rdata_d = (!pwrite_q && !PSLVERR) ? PRDATA : '0;
                    state_d = ST_RESP;
                end else if (cnt_q == C_TMO_LAST) begin
                    err_d   = 1'b1;
                    tout_d  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = tout_q;
    assign PSEL        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign PENABLE     = (state_q == ST_ACCESS);
    assign PADDR       = paddr_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;

endmodule : apb_cmd_master
`default_nettype wire

// File: tb/tb_apb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_cmd_master
// Brief    : Directed self-checking bench for apb_cmd_master with an APB slave model.
// Revision : 1.0
// ============================================================================
module tb_apb_cmd_master;

    logic        CLK;
    logic        RESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int n_chk = 0;
    int n_err = 0;

    // Slave model controls
    int          sl_wait;
    logic        sl_stuck;
    logic        sl_err;
    int          wcnt;
    logic [31:0] mem [4];

    // Per-transaction observations
    int          n_psel, n_acc, lat, stab_bad, addr_bad;
    logic [31:0] r_rdata;
    logic        r_err, r_tout;

    apb_cmd_master #(.TIMEOUT_CYCLES(16)) dut (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_write  (cmd_write),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .PADDR      (PADDR),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign PREADY  = PSEL && PENABLE && !sl_stuck && (wcnt >= sl_wait);
    assign PSLVERR = PREADY && sl_err;
    assign PRDATA  = (PADDR == 32'h0) ? 32'h5A5A_5A5A : mem[PADDR[3:2]];

    always @(posedge CLK) begin
        if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 1;
        else                            wcnt <= 0;
        if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR[3:2]] <= PWDATA;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Issue one command, track the bus, hold rsp_ready low for 'hold' cycles, then consume.
    task automatic do_cmd(input logic [31:0] a, input logic w, input logic [31:0] wd, input int hold);
        int guard;
        n_psel = 0; n_acc = 0; stab_bad = 0; addr_bad = 0;
        cmd_addr = a; cmd_write = w; cmd_wdata = wd; cmd_valid = 1'b1;
        chk("cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        lat = 1;
        guard = 0;
        while (!rsp_valid && guard < 100) begin
            if (PSEL) begin
                n_psel++;
                if (PADDR != a || PWRITE != w || (w && PWDATA != wd)) addr_bad++;
            end
            if (PSEL && PENABLE) n_acc++;
            @(posedge CLK); #1;
            lat++; guard++;
        end
        if (!rsp_valid) begin
            chk("rsp_wait", 32'(rsp_valid), 32'd1);
            return;
        end
        r_rdata = rsp_rdata; r_err = rsp_err; r_tout = rsp_timeout;
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); #1;
            if (!rsp_valid || rsp_rdata != r_rdata || rsp_err != r_err ||
                rsp_timeout != r_tout || PSEL) stab_bad++;
        end
        rsp_ready = 1'b1;
        @(posedge CLK); #1;
        rsp_ready = 1'b0;
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        RESETn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0;
        cmd_wdata = '0; rsp_ready = 1'b0;
        sl_wait = 0; sl_stuck = 1'b0; sl_err = 1'b0; wcnt = 0;
        for (int i = 0; i < 4; i++) mem[i] = 32'h0;

        #12;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_psel",      32'({PSEL, PENABLE}), 32'd0);
        chk("rst_paddr",     PADDR, 32'd0);
        chk("rst_rsp_err",   32'({rsp_err, rsp_timeout}), 32'd0);
        @(negedge CLK); RESETn = 1'b1;
        @(posedge CLK); #1;

        // Zero-wait read of the ID register
        do_cmd(32'h000, 1'b0, 32'h0, 0);
        chk("id_lat",   32'(lat), 32'd3);
        chk("id_psel",  32'(n_psel), 32'd2);
        chk("id_rdata", r_rdata, 32'h5A5A_5A5A);
        chk("id_err",   32'({r_err, r_tout}), 32'd0);
        chk("id_addr",  32'(addr_bad), 32'd0);

        // Write then read back
        do_cmd(32'h004, 1'b1, 32'h1234_5678, 0);
        chk("wr_err",   32'({r_err, r_tout}), 32'd0);
        chk("wr_rdata", r_rdata, 32'd0);
        chk("wr_addr",  32'(addr_bad), 32'd0);
        do_cmd(32'h004, 1'b0, 32'h0, 0);
        chk("rd_rdata", r_rdata, 32'h1234_5678);
        chk("rd_err",   32'(r_err), 32'd0);

        // Three wait states then slave error
        sl_wait = 3; sl_err = 1'b1;
        do_cmd(32'h008, 1'b1, 32'hCAFE_0001, 0);
        chk("slv_acc",  32'(n_acc), 32'd4);
        chk("slv_err",  32'(r_err), 32'd1);
        chk("slv_tout", 32'(r_tout), 32'd0);
        chk("slv_addr", 32'(addr_bad), 32'd0);
        sl_err = 1'b0;

        // Ready arrives on the 16th ACCESS cycle: normal completion
        sl_wait = 15;
        do_cmd(32'h00C, 1'b1, 32'h0BAD_F00D, 0);
        chk("edge_acc",  32'(n_acc), 32'd16);
        chk("edge_err",  32'({r_err, r_tout}), 32'd0);
        do_cmd(32'h00C, 1'b0, 32'h0, 0);
        chk("edge_rd",   r_rdata, 32'h0BAD_F00D);
        sl_wait = 0;

        // Stuck slave: timeout after 16 ACCESS cycles
        sl_stuck = 1'b1;
        do_cmd(32'h004, 1'b0, 32'h0, 0);
        chk("tmo_acc",   32'(n_acc), 32'd16);
        chk("tmo_psel",  32'(n_psel), 32'd17);
        chk("tmo_err",   32'({r_err, r_tout}), 32'd3);
        chk("tmo_rdata", r_rdata, 32'd0);
        sl_stuck = 1'b0;

        // Misaligned: no bus traffic, immediate error, held response
        do_cmd(32'h006, 1'b0, 32'h0, 5);
        chk("mis_psel",  32'(n_psel), 32'd0);
        chk("mis_lat",   32'(lat), 32'd1);
        chk("mis_err",   32'({r_err, r_tout}), 32'd2);
        chk("mis_rdata", r_rdata, 32'd0);
        chk("mis_stab",  32'(stab_bad), 32'd0);

        // Reset in the middle of ACCESS
        sl_stuck = 1'b1;
        cmd_addr = 32'h004; cmd_write = 1'b0; cmd_valid = 1'b1;
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("mid_in_access", 32'({PSEL, PENABLE}), 32'd3);
        #2 RESETn = 1'b0;
        #1;
        chk("mid_rst_psel",  32'({PSEL, PENABLE}), 32'd0);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_rsp",   32'(rsp_valid), 32'd0);
        sl_stuck = 1'b0;
        @(negedge CLK); RESETn = 1'b1;
        stab_bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK); #1;
            if (rsp_valid || PSEL) stab_bad++;
        end
        chk("mid_no_rsp", 32'(stab_bad), 32'd0);

        // Bus still usable after the abort
        do_cmd(32'h000, 1'b0, 32'h0, 0);
        chk("post_rdata", r_rdata, 32'h5A5A_5A5A);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule : tb_apb_cmd_master
`default_nettype wire

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of ACCESS-phase cycles to wait for PREADY (range 1..255).
REQ-002 SHALL have port CLK  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port RESETn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-006 SHALL have port cmd_addr  input  32  byte address.
REQ-007 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-008 SHALL have port cmd_wdata  input  32  write data.
REQ-009 SHALL have port rsp_valid  output  1  response available.
REQ-010 SHALL have port rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-011 SHALL have port rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-012 SHALL have port rsp_err  output  1  PSLVERR, timeout or misalignment.
REQ-013 SHALL have port rsp_timeout  output  1  error was a timeout.
REQ-014 SHALL have APB master ports PADDR(32), PSEL(1), PENABLE(1), PWRITE(1), PWDATA(32) as outputs, and PRDATA(32), PREADY(1), PSLVERR(1) as inputs.

Function
REQ-015 SHALL implement the FSM states IDLE, SETUP, ACCESS and RESP.
REQ-016 SHALL drive cmd_ready=1 only in IDLE; on cmd_valid&cmd_ready it SHALL latch addr/write/wdata and go to SETUP, or to RESP if cmd_addr[1:0]!=0.
REQ-017 SHALL treat a misaligned command as follows: no APB transfer, rsp_err=1, rsp_timeout=0, rsp_rdata=0.
REQ-018 SHALL drive PSEL=1, PENABLE=0 in SETUP for exactly one cycle, then go to ACCESS.
REQ-019 SHALL drive PSEL=1, PENABLE=1 in ACCESS; PADDR, PWRITE and PWDATA SHALL be stable from SETUP through the end of ACCESS.
REQ-020 SHALL, in ACCESS with PREADY=1: capture PRDATA (reads only), capture PSLVERR into rsp_err, and go to RESP.
REQ-021 SHALL count ACCESS cycles with PREADY=0; when the count reaches TIMEOUT_CYCLES it SHALL go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-022 SHALL make PREADY=1 on the same cycle as the timeout count being reached a normal completion, not a timeout.
REQ-023 SHALL hold rsp_valid=1 and the response fields constant in RESP until rsp_ready=1, then go to IDLE.
REQ-024 SHALL give a read with zero-wait PREADY the latency: accept cycle N, SETUP N+1, ACCESS N+2, rsp_valid N+3; maximum throughput is one transfer per 4 cycles.
REQ-025 SHALL drive PSEL=0 and PENABLE=0 outside SETUP/ACCESS; PADDR, PWRITE and PWDATA SHALL hold their last values there.
REQ-026 SHALL ignore PREADY, PRDATA and PSLVERR outside ACCESS.

Reset
REQ-027 SHALL, on RESETn low, immediately force state IDLE and all outputs to 0 except cmd_ready=1; the timeout counter SHALL clear.
REQ-028 SHALL abort any transfer in progress when reset is asserted mid-transfer; no response SHALL be produced for it.

Structure
REQ-029 SHALL place the FSM state enum, the default TIMEOUT_CYCLES and the APB data/address width constants in the shared package apb_pkg.
REQ-030 SHALL be a single module with no sub-modules; the timeout counter is inline, 8 bits wide.

Verification
REQ-031 SHALL check: read 0x000 from the ID register (returns 0x5A5A5A5A, PREADY=1) -> PSEL high for 2 cycles, rsp_valid at N+3, rsp_rdata=0x5A5A5A5A, rsp_err=0.
REQ-032 SHALL check: write 0x12345678 to 0x004, then read 0x004 -> write rsp_err=0, rsp_rdata=0; read returns 0x12345678.
REQ-033 SHALL check: slave holds PREADY=0 for 3 cycles then PSLVERR=1 -> ACCESS lasts 4 cycles, rsp_err=1, rsp_timeout=0.
REQ-034 SHALL check: PREADY stuck at 0 with TIMEOUT_CYCLES=16 -> after 16 ACCESS cycles PSEL drops, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-035 SHALL check: cmd_addr=0x006 -> PSEL never asserts, rsp_err=1 at the next cycle; rsp_ready held low for 5 cycles -> rsp_valid and fields stable throughout.
REQ-036 SHALL check: RESETn pulsed low during ACCESS -> PSEL/PENABLE=0 immediately, cmd_ready=1, no rsp_valid after release.
